// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the two-requester register-file access arbiter:
// default widths, FSM state encodings and requester identities.
package regfile_arb_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // One-hot grant vector for a requester: bit 0 = A, bit 1 = B.
    function automatic logic [1:0] grant_of(input req_id_t id);
        return (id == REQ_A) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/regfile_arb_rr_arb2.sv
// Two-way round-robin picker: a lone request always wins, and on a tie the
// requester that was not granted last time wins. Purely combinational.
module rr_arb2
    import regfile_arb_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  req_id_t    last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req_a && req_b) begin
            grant = (last_grant == REQ_B) ? grant_of(REQ_A) : grant_of(REQ_B);
        end else if (req_a) begin
            grant = grant_of(REQ_A);
        end else if (req_b) begin
            grant = grant_of(REQ_B);
        end
    end

endmodule

// File: rtl/regfile_arb.sv
// Arbitrates two requesters onto a single external register file port.
// Each transaction runs IDLE -> ACCESS -> DONE, acking the winner in DONE.
module regfile_arb
    import regfile_arb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_req,
    input  logic          b_req,
    input  logic          a_we,
    input  logic          b_we,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic [DW-1:0] b_wdata,
    output logic          a_ack,
    output logic          b_ack,
    output logic [DW-1:0] rdata,
    output logic [DW-1:0] rf_data_in,
    output logic [AW-1:0] rf_writenum,
    output logic [AW-1:0] rf_readnum,
    output logic          rf_write,
    input  logic [DW-1:0] rf_data_out
);

    state_t        state_reg,      state_next;
    req_id_t       owner_reg,      owner_next;
    req_id_t       last_grant_reg, last_grant_next;
    logic          we_reg,         we_next;
    logic [AW-1:0] addr_reg,       addr_next;
    logic [DW-1:0] wdata_reg,      wdata_next;
    logic [DW-1:0] rdata_reg;
    logic [1:0]    grant;

    rr_arb2 u_rr_arb2 (
        .req_a      (a_req),
        .req_b      (b_req),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= REQ_A;
            last_grant_reg <= REQ_B;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
        end
    end

    // Request inputs are only looked at in IDLE; everything after runs off the latched copy.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    state_next = ST_ACCESS;
                    if (grant[0]) begin
                        owner_next      = REQ_A;
                        last_grant_next = REQ_A;
                        we_next         = a_we;
                        addr_next       = a_addr;
                        wdata_next      = a_wdata;
                    end else begin
                        owner_next      = REQ_B;
                        last_grant_next = REQ_B;
                        we_next         = b_we;
                        addr_next       = b_addr;
                        wdata_next      = b_wdata;
                    end
                end
            end
            ST_ACCESS: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Read data is captured as ACCESS ends and held until the next read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_reg <= '0;
        end else if (state_reg == ST_ACCESS && !we_reg) begin
            rdata_reg <= rf_data_out;
        end
    end

    // Strobes decode straight from state so an asynchronous reset kills them at once.
    assign rf_write    = (state_reg == ST_ACCESS) && we_reg;
    assign rf_writenum = addr_reg;
    assign rf_readnum  = addr_reg;
    assign rf_data_in  = wdata_reg;
    assign rdata       = rdata_reg;
    assign a_ack       = (state_reg == ST_DONE) && (owner_reg == REQ_A);
    assign b_ack       = (state_reg == ST_DONE) && (owner_reg == REQ_B);

endmodule

// File: tb/tb_regfile_arb.sv
// Randomized scoreboard bench for regfile_arb with a transaction-level model
// of round-robin service order and register contents.
module tb_regfile_arb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic        a_we = 1'b0, b_we = 1'b0;
    logic [2:0]  a_addr = '0, b_addr = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;
    logic        a_ack, b_ack, rf_write;
    logic [15:0] rdata, rf_data_in, rf_data_out;
    logic [2:0]  rf_writenum, rf_readnum;

    regfile_arb #(.DW(16), .AW(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_ack(a_ack), .b_ack(b_ack), .rdata(rdata),
        .rf_data_in(rf_data_in), .rf_writenum(rf_writenum), .rf_readnum(rf_readnum),
        .rf_write(rf_write), .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;

    // External register file: synchronous write, combinational read.
    logic [15:0] rf_mem [8] = '{default: 16'h0000};
    always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
    assign rf_data_out = rf_mem[rf_readnum];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0, wr_seen = 0, exp_writes = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", nm, act, $time);
        end
    endtask

    typedef struct {
        bit          id;     // 0 = A, 1 = B
        bit          we;
        logic [15:0] rd;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    // Reference model: register contents, last winner, each requester's pending op.
    logic [15:0] mdl_mem [8] = '{default: 16'h0000};
    bit          mdl_last_b = 1'b1;
    bit          a_pend = 0, b_pend = 0;
    logic        a_mwe, b_mwe;
    logic [2:0]  a_maddr, b_maddr;
    logic [15:0] a_mwd, b_mwd;

    // Called in an IDLE cycle (just after a negedge); returns in the next IDLE cycle.
    task automatic slot(input bit na, input logic wa, input logic [2:0] ada, input logic [15:0] wda,
                        input bit nb, input logic wb, input logic [2:0] adb, input logic [15:0] wdb);
        exp_t        e;
        bit          win_b;
        logic        we;
        logic [2:0]  ad;
        logic [15:0] wd;
        if (na && !a_pend) begin
            a_pend = 1; a_mwe = wa; a_maddr = ada; a_mwd = wda;
            a_req = 1; a_we = wa; a_addr = ada; a_wdata = wda;
        end
        if (nb && !b_pend) begin
            b_pend = 1; b_mwe = wb; b_maddr = adb; b_mwd = wdb;
            b_req = 1; b_we = wb; b_addr = adb; b_wdata = wdb;
        end
        if (!a_pend && !b_pend) begin
            @(negedge clk);
            return;
        end
        win_b      = (a_pend && b_pend) ? !mdl_last_b : b_pend;
        mdl_last_b = win_b;
        we = win_b ? b_mwe   : a_mwe;
        ad = win_b ? b_maddr : a_maddr;
        wd = win_b ? b_mwd   : a_mwd;
        e.id  = win_b;
        e.we  = we;
        e.cyc = cyc + 2;
        e.rd  = mdl_mem[ad];
        if (we) begin
            mdl_mem[ad] = wd;
            exp_writes++;
        end
        sbq.push_back(e);
        @(negedge clk);  // ACCESS: scramble the winner's inputs; they must be ignored
        if (win_b) begin
            b_we = 1'($urandom); b_addr = 3'($urandom); b_wdata = 16'($urandom);
            if ($urandom_range(3) == 0) b_req = 0;
        end else begin
            a_we = 1'($urandom); a_addr = 3'($urandom); a_wdata = 16'($urandom);
            if ($urandom_range(3) == 0) a_req = 0;
        end
        @(negedge clk);  // DONE
        if (win_b) begin b_req = 0; b_pend = 0; end
        else       begin a_req = 0; a_pend = 0; end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && (a_pend || b_pend); k++)
            slot(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
    endtask

    // Monitor: pops the scoreboard on every ack and checks identity, timing, data.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (rf_write) wr_seen++;
            if (a_ack || b_ack) begin
                check("ack_onehot", {31'd0, a_ack & b_ack}, 32'd0);
                if (sbq.size() == 0) begin
                    check("spurious_ack", {30'd0, b_ack, a_ack}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("ack_id", {31'd0, b_ack}, {31'd0, e.id});
                    check("ack_cycle", cyc, e.cyc);
                    if (!e.we) check("rdata", {16'd0, rdata}, {16'd0, e.rd});
                end
            end else if (sbq.size() != 0 && cyc >= sbq[0].cyc) begin
                e = sbq.pop_front();
                check("ack_missing", {30'd0, b_ack, a_ack}, e.id ? 32'd2 : 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset_n = 0;
        repeat (2) @(negedge clk);
        check("rst_a_ack", {31'd0, a_ack}, 32'd0);
        check("rst_b_ack", {31'd0, b_ack}, 32'd0);
        check("rst_rf_write", {31'd0, rf_write}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_addr", {29'd0, rf_writenum}, 32'd0);
        check("rst_wdata", {16'd0, rf_data_in}, 32'd0);
        reset_n = 1;

        // Tie straight from reset: A first, then B; R1 ends as B's value.
        slot(1, 1, 3'd1, 16'hAAAA, 1, 1, 3'd1, 16'h5555);
        drain();
        check("r1_final", {16'd0, rf_mem[1]}, 32'h5555);

        // Lone A write then read back of R3.
        slot(1, 1, 3'd3, 16'h1234, 0, 0, 3'd0, 16'h0);
        slot(1, 0, 3'd3, 16'h0,    0, 0, 3'd0, 16'h0);

        // Put B last, so a tie goes to A's write of R5 ahead of B's read.
        slot(0, 0, 3'd0, 16'h0, 1, 0, 3'd0, 16'h0);
        slot(1, 1, 3'd5, 16'hBEEF, 1, 0, 3'd5, 16'h0);
        drain();

        // Both held continuously reading R0..R7: service must alternate.
        for (int i = 0; i < 8; i++)
            slot(1, 0, 3'(i), 16'h0, 1, 0, 3'(7 - i), 16'h0);
        drain();

        // Reset in the middle of an A write to R2.
        a_req = 1; a_we = 1; a_addr = 3'd2; a_wdata = 16'hFFFF;
        @(negedge clk);
        check("mid_rf_write", {31'd0, rf_write}, 32'd1);
        exp_writes++;
        #2 reset_n = 0;
        #1;
        check("rst_kill_write", {31'd0, rf_write}, 32'd0);
        check("rst_kill_rdata", {16'd0, rdata}, 32'd0);
        a_req = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        check("rst_no_ack", {31'd0, a_ack}, 32'd0);
        check("r2_unchanged", {16'd0, rf_mem[2]}, {16'd0, mdl_mem[2]});
        mdl_last_b = 1'b1;
        slot(1, 0, 3'd2, 16'h0, 1, 0, 3'd4, 16'h0);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 200; n++)
            slot($urandom_range(3) != 0, 1'($urandom), 3'($urandom), 16'($urandom),
                 $urandom_range(3) != 0, 1'($urandom), 3'($urandom), 16'($urandom));
        drain();

        repeat (3) @(negedge clk);
        check("sb_empty", sbq.size(), 32'd0);
        check("write_count", wr_seen, exp_writes);
        for (int r = 0; r < 8; r++)
            check($sformatf("mem_r%0d", r), {16'd0, rf_mem[r]}, {16'd0, mdl_mem[r]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_arb.md
REGFILE_ARB -- requirements
Module: regfile_arb

Interface
REQ-001 Parameter DW, default 16, data width of the register file word.
REQ-002 Parameter AW, default 3, register address width (8 registers).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 a_req, b_req  input  1 each  access request from requester A / B; held high until acked.
REQ-006 a_we, b_we  input  1 each  1 = write, 0 = read; valid while the matching req is high.
REQ-007 a_addr, b_addr  input  AW each  target register number.
REQ-008 a_wdata, b_wdata  input  DW each  write data.
REQ-009 a_ack, b_ack  output  1 each  one-cycle completion pulse to A / B.
REQ-010 rdata  output  DW  read result; valid in the ack cycle of a read.
REQ-011 rf_data_in  output  DW  to register file data_in.
REQ-012 rf_writenum, rf_readnum  output  AW each  to register file writenum / readnum.
REQ-013 rf_write  output  1  to register file write.
REQ-014 rf_data_out  input  DW  from register file data_out (combinational read).

Function
REQ-015 FSM states IDLE, ACCESS, DONE; ACCESS and DONE each last exactly one cycle.
REQ-016 IDLE: no req -> stay; any req -> select winner, latch its we/addr/wdata and identity, go ACCESS.
REQ-017 Arbitration is round-robin: only one req -> it wins; both -> the requester not granted last wins.
REQ-018 last_grant register updated on every IDLE->ACCESS transition.
REQ-019 ACCESS: rf_writenum = rf_readnum = latched addr, rf_data_in = latched wdata, rf_write = latched we; go DONE.
REQ-020 Write commits into the register file at the clock edge ending ACCESS.
REQ-021 Read: rf_data_out captured into rdata at the edge ending ACCESS.
REQ-022 DONE: ack of the latched requester = 1, other ack = 0, rf_write = 0; go IDLE unconditionally.
REQ-023 Latency: req seen in IDLE at cycle N -> ACCESS N+1 -> ack N+2; one transaction per 3 cycles maximum.
REQ-024 Requester drops req (or presents a new request) at the edge where it samples ack; req high in the IDLE cycle after DONE is a new transaction.
REQ-025 Outside ACCESS: rf_write = 0; rf_writenum, rf_readnum, rf_data_in hold latched values.
REQ-026 rdata holds its value until the next read capture; writes do not modify rdata.
REQ-027 Changes to req/we/addr/wdata after the IDLE latch have no effect on the transaction in flight.
REQ-028 Requester withdrawing req during ACCESS/DONE does not abort; transaction completes and acks.

Reset
REQ-029 reset_n low forces immediately: state IDLE, a_ack = b_ack = 0, rf_write = 0, rdata = 0, latched addr/wdata/we = 0, last_grant = B (A wins first tie).
REQ-030 Reset during ACCESS aborts: no register write occurs, no ack is issued after reset release.
REQ-031 First arbitration possible in the first IDLE cycle after reset_n rises.

Structure
REQ-032 Shared package holds DW/AW defaults, state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), requester IDs (A=0, B=1).
REQ-033 One sub-module: rr_arb2 (two-way round-robin picker: two reqs + last_grant in, one-hot grant out, combinational).
REQ-034 regfile_arb does not instantiate the register file; the parent connects rf_* ports.

Verification
REQ-035 A writes R3=16'h1234 alone -> rf_write high exactly one cycle with rf_writenum=3; a_ack at cycle N+2; later A read of R3 returns rdata=16'h1234 with a_ack.
REQ-036 A and B request together from reset (A write R1=16'hAAAA, B write R1=16'h5555) -> A served first, B next; final R1=16'h5555; acks 3 cycles apart.
REQ-037 A and B both held continuously, reads of R0..R7 -> grants alternate A,B,A,B; no requester starved; no ack to both in one cycle.
REQ-038 B read of R5 while A writes R5=16'hBEEF granted first -> B rdata=16'hBEEF.
REQ-039 reset_n pulsed low mid-ACCESS of A write R2=16'hFFFF -> rf_write falls immediately, R2 unchanged, no a_ack; post-reset tie grants A.
REQ-040 A changes a_addr/a_wdata during ACCESS -> write uses values latched in IDLE.
